// File: rtl/mat_row_store_pkg.sv
// Shared definitions for the row-organised complex-matrix store: default
// geometry, element layout and controller state encoding.
package mat_row_store_pkg;

  // Default geometry: 4x4 matrix of complex doubles.
  localparam int SIZE_DEF  = 4;
  localparam int WIDTH_DEF = 64;
  localparam int AW_DEF    = (SIZE_DEF > 1) ? $clog2(SIZE_DEF) : 1;
  localparam int ROW_W_DEF = SIZE_DEF * 2 * WIDTH_DEF;

  // One complex element as it sits inside a row: imag in the upper half.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] im;
    logic [WIDTH_DEF-1:0] re;
  } cplx_t;

  // Controller states. SERVE is the all-zero encoding so reset lands there.
  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;

  // Row-address width; a one-row store still gets a one-bit address.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_row_store_rd_port.sv
// Registered row read port: one-cycle latency, write-first forwarding from
// the client write-back port, and zero rows for out-of-range addresses.
module mat_row_store_rd_port
  import mat_row_store_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW    = calc_aw(SIZE),
  localparam int ROW_W = SIZE * 2 * WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,        // reads are only served in SERVE
  input  logic [AW-1:0]              rd_addr_i,
  input  logic                       rd_valid_i,
  input  logic [SIZE-1:0][ROW_W-1:0] mem_i,
  input  logic                       wr_en_i,     // write actually committing this cycle
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [ROW_W-1:0]           wr_row_i,
  output logic [ROW_W-1:0]           row_o,
  output logic [AW-1:0]              row_addr_o,
  output logic                       row_valid_o
);

  logic             in_range;
  logic [ROW_W-1:0] src_row;
  logic [ROW_W-1:0] row_d,   row_q;
  logic [AW-1:0]    addr_d,  addr_q;
  logic             valid_d, valid_q;

  // Select the row to return: forwarded write data beats stored data, and an
  // address past the end of the matrix reads as zero.
  always_comb begin
    in_range = (int'(rd_addr_i) < SIZE);
    src_row  = in_range ? mem_i[rd_addr_i] : '0;
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      src_row = wr_row_i;
    end
    valid_d = en_i & rd_valid_i;
    row_d   = valid_d ? src_row   : row_q;
    addr_d  = valid_d ? rd_addr_i : addr_q;
  end

  // Output register; data and address hold between requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign row_o       = row_q;
  assign row_addr_o  = addr_q;
  assign row_valid_o = valid_q;

endmodule

// File: rtl/mat_row_store.sv
// Row-organised complex-matrix store. Serves two registered read clients,
// one client write-back port, and host load/dump streams that walk rows
// 0..SIZE-1 in order.
module mat_row_store
  import mat_row_store_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW    = calc_aw(SIZE),
  localparam int ROW_W = SIZE * 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // client A (read + write-back)
  input  logic [AW-1:0]    a_rd_addr_i,
  input  logic             a_rd_addr_valid_i,
  output logic [ROW_W-1:0] a_row_o,
  output logic [AW-1:0]    a_row_addr_o,
  output logic             a_row_valid_o,
  input  logic [ROW_W-1:0] a_wr_row_i,
  input  logic [AW-1:0]    a_wr_addr_i,
  input  logic             a_wr_valid_i,
  output logic             a_wr_ready_o,
  // client B (read only)
  input  logic [AW-1:0]    b_rd_addr_i,
  input  logic             b_rd_addr_valid_i,
  output logic [ROW_W-1:0] b_row_o,
  output logic [AW-1:0]    b_row_addr_o,
  output logic             b_row_valid_o,
  // host load stream
  input  logic             load_start_i,
  input  logic [ROW_W-1:0] ld_row_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  // host dump stream
  input  logic             dump_start_i,
  output logic [ROW_W-1:0] dump_row_o,
  output logic             dump_valid_o,
  input  logic             dump_ready_i,
  // control / status
  input  logic             flush_i,
  output logic             busy_o
);

  logic [1:0]                state_d, state_q;
  logic [AW-1:0]             cnt_d,   cnt_q;
  logic [SIZE-1:0][ROW_W-1:0] mem_d,  mem_q;

  logic            in_serve, in_load, in_dump;
  logic            last_cnt;
  logic            ld_fire, dump_fire, wr_fire;
  logic            wr_in_range;
  logic [SIZE-1:0] row_wr, row_ld;

  assign in_serve    = (state_q == ST_SERVE);
  assign in_load     = (state_q == ST_LOAD);
  assign in_dump     = (state_q == ST_DUMP);
  assign last_cnt    = (int'(cnt_q) == SIZE - 1);
  assign ld_fire     = in_load & ld_valid_i;
  assign dump_fire   = in_dump & dump_ready_i;
  assign wr_in_range = (int'(a_wr_addr_i) < SIZE);
  // Client writes land only in SERVE; out-of-range addresses are dropped.
  assign wr_fire     = in_serve & a_wr_valid_i & wr_in_range;

  // Controller: pick up start requests in SERVE, walk the row counter in
  // LOAD/DUMP, and let flush abandon any transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SERVE: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else if (dump_start_i) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          if (last_cnt) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_DUMP: begin
        if (dump_fire) begin
          if (last_cnt) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_SERVE;
        cnt_d   = '0;
      end
    endcase
    // Flush wins over everything, but a beat accepted this cycle still
    // commits its memory write below.
    if (flush_i) begin
      state_d = ST_SERVE;
      cnt_d   = '0;
    end
  end

  // Controller registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SERVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-row write strobes: host load targets the counter row, the client
  // write-back targets its address. The two never coincide (LOAD vs SERVE).
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row_sel
    assign row_ld[gi] = ld_fire && (int'(cnt_q) == gi);
    assign row_wr[gi] = wr_fire && (int'(a_wr_addr_i) == gi);
  end

  // Next memory contents.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < SIZE; i++) begin
      if (row_ld[i]) begin
        mem_d[i] = ld_row_i;
      end else if (row_wr[i]) begin
        mem_d[i] = a_wr_row_i;
      end
    end
  end

  // Row storage; reset clears the whole matrix, so this is a register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  mat_row_store_rd_port #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_rd_a (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (in_serve),
    .rd_addr_i   (a_rd_addr_i),
    .rd_valid_i  (a_rd_addr_valid_i),
    .mem_i       (mem_q),
    .wr_en_i     (wr_fire),
    .wr_addr_i   (a_wr_addr_i),
    .wr_row_i    (a_wr_row_i),
    .row_o       (a_row_o),
    .row_addr_o  (a_row_addr_o),
    .row_valid_o (a_row_valid_o)
  );

  mat_row_store_rd_port #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_rd_b (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (in_serve),
    .rd_addr_i   (b_rd_addr_i),
    .rd_valid_i  (b_rd_addr_valid_i),
    .mem_i       (mem_q),
    .wr_en_i     (wr_fire),
    .wr_addr_i   (a_wr_addr_i),
    .wr_row_i    (a_wr_row_i),
    .row_o       (b_row_o),
    .row_addr_o  (b_row_addr_o),
    .row_valid_o (b_row_valid_o)
  );

  assign a_wr_ready_o = in_serve;
  assign ld_ready_o   = in_load;
  assign dump_valid_o = in_dump;
  assign dump_row_o   = in_dump ? mem_q[cnt_q] : '0;
  assign busy_o       = ~in_serve;

endmodule

// File: tb/tb_mat_row_store.sv
// Self-checking bench for mat_row_store: directed load/dump/flush/reset
// scenarios plus randomized client traffic against a row-array model.
module tb_mat_row_store;

  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int AW    = 2;
  localparam int ROW_W = SIZE * 2 * WIDTH;

  typedef logic [ROW_W-1:0] row_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] a_rd_addr_i;
  logic          a_rd_addr_valid_i;
  row_t          a_row_o;
  logic [AW-1:0] a_row_addr_o;
  logic          a_row_valid_o;
  row_t          a_wr_row_i;
  logic [AW-1:0] a_wr_addr_i;
  logic          a_wr_valid_i;
  logic          a_wr_ready_o;
  logic [AW-1:0] b_rd_addr_i;
  logic          b_rd_addr_valid_i;
  row_t          b_row_o;
  logic [AW-1:0] b_row_addr_o;
  logic          b_row_valid_o;
  logic          load_start_i;
  row_t          ld_row_i;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic          dump_start_i;
  row_t          dump_row_o;
  logic          dump_valid_o;
  logic          dump_ready_i;
  logic          flush_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  mat_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .a_rd_addr_i       (a_rd_addr_i),
    .a_rd_addr_valid_i (a_rd_addr_valid_i),
    .a_row_o           (a_row_o),
    .a_row_addr_o      (a_row_addr_o),
    .a_row_valid_o     (a_row_valid_o),
    .a_wr_row_i        (a_wr_row_i),
    .a_wr_addr_i       (a_wr_addr_i),
    .a_wr_valid_i      (a_wr_valid_i),
    .a_wr_ready_o      (a_wr_ready_o),
    .b_rd_addr_i       (b_rd_addr_i),
    .b_rd_addr_valid_i (b_rd_addr_valid_i),
    .b_row_o           (b_row_o),
    .b_row_addr_o      (b_row_addr_o),
    .b_row_valid_o     (b_row_valid_o),
    .load_start_i      (load_start_i),
    .ld_row_i          (ld_row_i),
    .ld_valid_i        (ld_valid_i),
    .ld_ready_o        (ld_ready_o),
    .dump_start_i      (dump_start_i),
    .dump_row_o        (dump_row_o),
    .dump_valid_o      (dump_valid_o),
    .dump_ready_i      (dump_ready_i),
    .flush_i           (flush_i),
    .busy_o            (busy_o)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  row_t model_mem [SIZE];

  task automatic chk(input string tag, input row_t got, input row_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Row r, element j = (10r + j) + j(-r), packed {imag, real}.
  function automatic row_t test_row(input int r);
    row_t row;
    for (int j = 0; j < SIZE; j++) begin
      row[j*2*WIDTH +: 2*WIDTH] = {$realtobits(-real'(r)), $realtobits(real'(10 * r + j))};
    end
    return row;
  endfunction

  // Every element 1.0 + j0.0.
  function automatic row_t ones_row();
    row_t row;
    for (int j = 0; j < SIZE; j++) begin
      row[j*2*WIDTH +: 2*WIDTH] = {$realtobits(0.0), $realtobits(1.0)};
    end
    return row;
  endfunction

  // Read one row on both clients and compare with the model.
  task automatic read_both(input int addr);
    a_rd_addr_i = AW'(addr); b_rd_addr_i = AW'(addr);
    a_rd_addr_valid_i = 1'b1; b_rd_addr_valid_i = 1'b1;
    step();
    a_rd_addr_valid_i = 1'b0; b_rd_addr_valid_i = 1'b0;
    $display("read row %0d", addr);
    chk("rd_a_row",   a_row_o,              model_mem[addr]);
    chk("rd_b_row",   b_row_o,              model_mem[addr]);
    chk("rd_a_valid", row_t'(a_row_valid_o), row_t'(1));
    chk("rd_b_valid", row_t'(b_row_valid_o), row_t'(1));
  endtask

  task automatic read_all();
    for (int r = 0; r < SIZE; r++) read_both(r);
  endtask

  // Host load of all rows with random gaps in ld_valid_i.
  task automatic host_load();
    int k = 0;
    int guard = 0;
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    chk("load_busy", row_t'(busy_o), row_t'(1));
    while (k < SIZE && guard < 200) begin
      chk("ld_ready", row_t'(ld_ready_o), row_t'(1));
      ld_valid_i = ($urandom_range(0, 2) != 0);
      ld_row_i   = test_row(k);
      step();
      if (ld_valid_i) begin
        model_mem[k] = test_row(k);
        $display("load beat row %0d", k);
        k++;
      end
      guard++;
    end
    ld_valid_i = 1'b0;
    chk("load_done_cnt", row_t'(k), row_t'(SIZE));
    chk("load_busy_end", row_t'(busy_o), row_t'(0));
    chk("load_ready_end", row_t'(ld_ready_o), row_t'(0));
  endtask

  // Host dump with dump_ready_i toggling, starting with a stall.
  task automatic host_dump();
    int k = 0;
    int guard = 0;
    logic tog = 1'b0;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    while (k < SIZE && guard < 200) begin
      chk("dump_valid", row_t'(dump_valid_o), row_t'(1));
      chk("dump_row",   dump_row_o,           model_mem[k]);
      dump_ready_i = tog;
      tog = ~tog;
      step();
      if (dump_ready_i) begin
        $display("dump beat row %0d", k);
        k++;
      end
      guard++;
    end
    dump_ready_i = 1'b0;
    chk("dump_done_cnt",   row_t'(k), row_t'(SIZE));
    chk("dump_busy_end",   row_t'(busy_o), row_t'(0));
    chk("dump_valid_end",  row_t'(dump_valid_o), row_t'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t wdata;
    row_t new0, new1;

    rst_i = 1'b1;
    a_rd_addr_i = '0; a_rd_addr_valid_i = 1'b0;
    a_wr_row_i = '0; a_wr_addr_i = '0; a_wr_valid_i = 1'b0;
    b_rd_addr_i = '0; b_rd_addr_valid_i = 1'b0;
    load_start_i = 1'b0; ld_row_i = '0; ld_valid_i = 1'b0;
    dump_start_i = 1'b0; dump_ready_i = 1'b0; flush_i = 1'b0;
    for (int r = 0; r < SIZE; r++) model_mem[r] = '0;

    // Reset state.
    step(); step();
    $display("reset");
    chk("rst_a_valid",  row_t'(a_row_valid_o), row_t'(0));
    chk("rst_b_valid",  row_t'(b_row_valid_o), row_t'(0));
    chk("rst_a_row",    a_row_o,               row_t'(0));
    chk("rst_wr_ready", row_t'(a_wr_ready_o),  row_t'(1));
    chk("rst_ld_ready", row_t'(ld_ready_o),    row_t'(0));
    chk("rst_dump_v",   row_t'(dump_valid_o),  row_t'(0));
    chk("rst_dump_row", dump_row_o,            row_t'(0));
    chk("rst_busy",     row_t'(busy_o),        row_t'(0));
    rst_i = 1'b0;
    step();
    read_all();

    // Load rows 0..3 then dump them back with a toggling ready.
    host_load();
    host_dump();

    // Same-address read on both clients: one-cycle valid pulse.
    a_rd_addr_i = 2'd2; b_rd_addr_i = 2'd2;
    a_rd_addr_valid_i = 1'b1; b_rd_addr_valid_i = 1'b1;
    step();
    a_rd_addr_valid_i = 1'b0; b_rd_addr_valid_i = 1'b0;
    $display("dual read row 2");
    chk("dual_a_row",   a_row_o,              model_mem[2]);
    chk("dual_b_row",   b_row_o,              model_mem[2]);
    chk("dual_a_addr",  row_t'(a_row_addr_o), row_t'(2));
    chk("dual_b_addr",  row_t'(b_row_addr_o), row_t'(2));
    chk("dual_a_valid", row_t'(a_row_valid_o), row_t'(1));
    chk("dual_b_valid", row_t'(b_row_valid_o), row_t'(1));
    step();
    chk("dual_a_drop",  row_t'(a_row_valid_o), row_t'(0));
    chk("dual_b_drop",  row_t'(b_row_valid_o), row_t'(0));

    // Write row 1 while both clients read it: new data returned.
    a_wr_row_i = ones_row(); a_wr_addr_i = 2'd1; a_wr_valid_i = 1'b1;
    a_rd_addr_i = 2'd1; b_rd_addr_i = 2'd1;
    a_rd_addr_valid_i = 1'b1; b_rd_addr_valid_i = 1'b1;
    chk("fwd_wr_ready", row_t'(a_wr_ready_o), row_t'(1));
    step();
    a_wr_valid_i = 1'b0; a_rd_addr_valid_i = 1'b0; b_rd_addr_valid_i = 1'b0;
    model_mem[1] = ones_row();
    $display("write-forward row 1");
    chk("fwd_a_row", a_row_o, ones_row());
    chk("fwd_b_row", b_row_o, ones_row());
    read_both(1);

    // Load aborted by flush on the second beat; that beat still commits.
    new0 = rand_row(); new1 = rand_row();
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    ld_valid_i = 1'b1; ld_row_i = new0;
    step();
    ld_row_i = new1; flush_i = 1'b1;
    step();
    ld_valid_i = 1'b0; flush_i = 1'b0;
    model_mem[0] = new0; model_mem[1] = new1;
    $display("load flushed after 2 beats");
    chk("flush_busy",     row_t'(busy_o),       row_t'(0));
    chk("flush_wr_ready", row_t'(a_wr_ready_o), row_t'(1));
    chk("flush_ld_ready", row_t'(ld_ready_o),   row_t'(0));
    read_all();

    // Client writes and reads during DUMP are refused.
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    a_wr_row_i = rand_row(); a_wr_addr_i = 2'd0; a_wr_valid_i = 1'b1;
    a_rd_addr_i = 2'd0; b_rd_addr_i = 2'd3;
    a_rd_addr_valid_i = 1'b1; b_rd_addr_valid_i = 1'b1;
    chk("dump_wr_ready", row_t'(a_wr_ready_o), row_t'(0));
    chk("dump_busy",     row_t'(busy_o),       row_t'(1));
    step();
    a_wr_valid_i = 1'b0; a_rd_addr_valid_i = 1'b0; b_rd_addr_valid_i = 1'b0;
    $display("client access during dump");
    chk("dump_a_noval", row_t'(a_row_valid_o), row_t'(0));
    chk("dump_b_noval", row_t'(b_row_valid_o), row_t'(0));
    chk("dump_row0",    dump_row_o,            model_mem[0]);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("dump_flush_busy", row_t'(busy_o), row_t'(0));
    read_both(0);

    // Randomized client traffic in SERVE.
    for (int t = 0; t < 150; t++) begin
      logic [AW-1:0] ra, rb, wa;
      logic va, vb, wv;
      row_t exp_a, exp_b;
      ra = AW'($urandom_range(0, SIZE - 1));
      rb = AW'($urandom_range(0, SIZE - 1));
      wa = AW'($urandom_range(0, SIZE - 1));
      va = 1'($urandom_range(0, 1));
      vb = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      wdata = rand_row();
      exp_a = (wv && wa == ra) ? wdata : model_mem[ra];
      exp_b = (wv && wa == rb) ? wdata : model_mem[rb];
      a_rd_addr_i = ra; a_rd_addr_valid_i = va;
      b_rd_addr_i = rb; b_rd_addr_valid_i = vb;
      a_wr_addr_i = wa; a_wr_valid_i = wv; a_wr_row_i = wdata;
      chk("rnd_wr_ready", row_t'(a_wr_ready_o), row_t'(1));
      step();
      if (wv) model_mem[wa] = wdata;
      $display("rnd %0d: rdA=%0d/%0b rdB=%0d/%0b wr=%0d/%0b", t, ra, va, rb, vb, wa, wv);
      chk("rnd_a_valid", row_t'(a_row_valid_o), row_t'(va));
      chk("rnd_b_valid", row_t'(b_row_valid_o), row_t'(vb));
      if (va) begin
        chk("rnd_a_row",  a_row_o,              exp_a);
        chk("rnd_a_addr", row_t'(a_row_addr_o), row_t'(ra));
      end
      if (vb) begin
        chk("rnd_b_row",  b_row_o,              exp_b);
        chk("rnd_b_addr", row_t'(b_row_addr_o), row_t'(rb));
      end
    end
    a_rd_addr_valid_i = 1'b0; b_rd_addr_valid_i = 1'b0; a_wr_valid_i = 1'b0;
    step();
    host_dump();

    // Reset in the middle of a dump.
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    dump_ready_i = 1'b1;
    step();
    rst_i = 1'b1;
    dump_ready_i = 1'b0;
    step();
    $display("reset mid-dump");
    chk("mrst_busy",   row_t'(busy_o),       row_t'(0));
    chk("mrst_dump_v", row_t'(dump_valid_o), row_t'(0));
    chk("mrst_wr_rdy", row_t'(a_wr_ready_o), row_t'(1));
    rst_i = 1'b0;
    for (int r = 0; r < SIZE; r++) model_mem[r] = '0;
    step();
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
